// File: rtl/dram_stream_source_pkg.sv
// Shared definitions for both ends of the streaming SDRAM read interface:
// source FSM encodings, prefetcher FSM encodings and default word/address widths.
package dram_stream_source_pkg;

   localparam int DEF_WIDTH = 24;
   localparam int DEF_ABITS = 21;

   typedef enum logic [1:0] {
      SRC_IDLE  = 2'h0,
      SRC_ISSUE = 2'h1,
      SRC_WAIT  = 2'h2,
      SRC_DONE  = 2'h3
   } src_state_t;

   // Prefetcher side: number of words held in its two-word store.
   typedef enum logic [1:0] {
      PF_EMPTY = 2'h0,
      PF_ONE   = 2'h1,
      PF_TWO   = 2'h2
   } pf_state_t;

endpackage

// File: rtl/dram_stream_source_credit.sv
// dram_credit_counter: saturating up/down credit counter with clear and load-to-one.
// A credit arriving at saturation is dropped.
module dram_credit_counter #(
   parameter int CREDITS = 2,
   parameter int CBITS   = $clog2(CREDITS + 1)
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CBITS-1:0] count_o
);

   logic [CBITS-1:0] count_q;
   logic             full;

   assign full    = (count_q == CBITS'(CREDITS));
   assign count_o = count_q;

   always_ff @(posedge clock_i) begin
      if (reset_i || clear_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= CBITS'(1);
      end else if (inc_i && !dec_i && !full) begin
         count_q <= count_q + CBITS'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_q <= count_q - CBITS'(1);
      end
   end

`ifdef __icarus
   always_ff @(posedge clock_i) begin
      if (!reset_i && !clear_i && !load_i && inc_i && !dec_i && full)
         $error("dram_credit_counter: credit at saturation, request dropped");
   end
`endif

endmodule

// File: rtl/dram_stream_source.sv
// Streams words from the SDRAM acquisition buffer to the prefetcher, one read per credit,
// never overtaking the writer. Define DRAM_SOURCE_ONESHOT_EN to stop at LIMIT instead of wrapping.
module dram_stream_source
   import dram_stream_source_pkg::*;
#(
   parameter int          WIDTH   = DEF_WIDTH,
   parameter int          ABITS   = DEF_ABITS,
   parameter int unsigned LIMIT   = (1 << ABITS) - 1,
   parameter int          CREDITS = 2
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic [ABITS-1:0] wr_addr_i,
   input  logic             request_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] data_o,
   output logic             cmd_request_o,
   input  logic             cmd_accept_i,
   output logic [ABITS-1:0] cmd_address_o,
   input  logic             rd_valid_i,
   input  logic [WIDTH-1:0] rd_data_i,
   output logic [ABITS-1:0] rd_addr_o,
   output logic             busy_o,
`ifdef DRAM_SOURCE_ONESHOT_EN
   output logic             done_o,
`endif
   output src_state_t       state_o
);

   localparam int               CBITS     = $clog2(CREDITS + 1);
   localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(LIMIT);

   // Handshake: cmd_request_o is held with a stable cmd_address_o until the cycle
   // cmd_accept_i is high; ready_o is a one-cycle strobe qualifying data_o.
   src_state_t       state_q, state_d;
   logic             enable_q;
   logic [CBITS-1:0] credit;
   logic [ABITS-1:0] rd_addr_q, cmd_addr_q, next_addr;
   logic [WIDTH-1:0] data_q;
   logic             ready_q;
   logic             start, accept, deliver, at_limit, credit_clear;

   assign at_limit = (rd_addr_q == LAST_ADDR);
   assign start    = (state_q == SRC_IDLE) && enable_i && (credit != '0) && (rd_addr_q != wr_addr_i);
   assign accept   = (state_q == SRC_ISSUE) && cmd_accept_i;
   assign deliver  = (state_q == SRC_WAIT) && rd_valid_i;

`ifdef DRAM_SOURCE_ONESHOT_EN
   logic last_q;
   assign next_addr    = at_limit ? rd_addr_q : rd_addr_q + ABITS'(1);
   assign credit_clear = !enable_i || (state_q == SRC_DONE);
   assign done_o       = (state_q == SRC_DONE);
`else
   assign next_addr    = at_limit ? '0 : rd_addr_q + ABITS'(1);
   assign credit_clear = !enable_i;
`endif

   // Follows enable_i even through reset so a reset with enable held high
   // does not look like a fresh stream start.
   always_ff @(posedge clock_i) begin
      enable_q <= enable_i;
   end

   dram_credit_counter #(
      .CREDITS (CREDITS),
      .CBITS   (CBITS)
   ) u_credit (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .clear_i (credit_clear),
      .load_i  (enable_i && !enable_q),
      .inc_i   (request_i),
      .dec_i   (accept),
      .count_o (credit)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         SRC_IDLE:  if (start) state_d = SRC_ISSUE;
         SRC_ISSUE: if (cmd_accept_i) state_d = SRC_WAIT;
`ifdef DRAM_SOURCE_ONESHOT_EN
         SRC_WAIT:  if (rd_valid_i) state_d = last_q ? SRC_DONE : SRC_IDLE;
         SRC_DONE:  if (!enable_i) state_d = SRC_IDLE;
`else
         SRC_WAIT:  if (rd_valid_i) state_d = SRC_IDLE;
`endif
         default:   state_d = SRC_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= SRC_IDLE;
         rd_addr_q  <= '0;
         cmd_addr_q <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
`ifdef DRAM_SOURCE_ONESHOT_EN
         last_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ready_q <= deliver;
         if (start)   cmd_addr_q <= rd_addr_q;
         if (accept)  rd_addr_q  <= next_addr;
         if (deliver) data_q     <= rd_data_i;
`ifdef DRAM_SOURCE_ONESHOT_EN
         if (accept) last_q <= at_limit;
         if ((state_q == SRC_DONE) && !enable_i) begin
            rd_addr_q <= '0;
            last_q    <= 1'b0;
         end
`endif
      end
   end

`ifdef __icarus
   always_ff @(posedge clock_i) begin
      if (!reset_i && rd_valid_i && (state_q != SRC_WAIT))
         $error("dram_stream_source: rd_valid_i outside WAIT ignored");
   end
`endif

   assign cmd_request_o = (state_q == SRC_ISSUE);
   assign cmd_address_o = cmd_addr_q;
   assign rd_addr_o     = rd_addr_q;
   assign busy_o        = (state_q != SRC_IDLE);
   assign ready_o       = ready_q;
   assign data_o        = data_q;
   assign state_o       = state_q;

endmodule
